// File: rtl/instruction_dispatch_if.sv
// Dispatch-stage bundle: instruction queue head handshake, reservation-station
// availability, and the issue strobes/payload toward the back end.
interface instruction_dispatch_if #(
  parameter int unsigned TAG_W = 4
);
  logic              iq_valid;
  logic [74:0]       iq_instr;
  logic              iq_ready;
  logic              rs_int_free;
  logic              rs_fadd_free;
  logic              rs_fmul_free;
  logic              lsb_free;
  logic              rob_full;
  logic              disp_int;
  logic              disp_fadd;
  logic              disp_fmul;
  logic              disp_lsb;
  logic [74:0]       disp_instr;
  logic [TAG_W-1:0]  disp_tag;

  modport master (
    input  iq_valid, iq_instr, rs_int_free, rs_fadd_free, rs_fmul_free,
           lsb_free, rob_full,
    output iq_ready, disp_int, disp_fadd, disp_fmul, disp_lsb, disp_instr,
           disp_tag
  );

  modport slave (
    output iq_valid, iq_instr, rs_int_free, rs_fadd_free, rs_fmul_free,
           lsb_free, rob_full,
    input  iq_ready, disp_int, disp_fadd, disp_fmul, disp_lsb, disp_instr,
           disp_tag
  );
endinterface

// File: rtl/instruction_dispatch.sv
// In-order single-entry dispatcher: holds one decoded head entry, issues it to
// the matching reservation station when that unit and the ROB can accept it.
module instruction_dispatch #(
  parameter int unsigned TAG_W   = 4,
  parameter int unsigned STALL_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  instruction_dispatch_if.master bus,
  output logic                 illegal_op,
  output logic [STALL_W-1:0]   stall_cycles
);

  typedef enum logic {EMPTY = 1'b0, HOLD = 1'b1} state_t;
  typedef enum logic [2:0] {
    CL_INT, CL_FADD, CL_FMUL, CL_LSB, CL_NOP, CL_ILL
  } class_t;

  state_t           state, state_nxt;
  class_t           cls;
  logic [74:0]      hold_instr;
  logic [TAG_W-1:0] tag;
  logic             hold_vld;
  logic             target_free;
  logic             fire;
  logic             ready;
  logic             accept;
  logic             issue;

  always_comb begin
    cls = CL_ILL;
    unique case (hold_instr[74:71])
      4'h0, 4'h1, 4'h2, 4'h3, 4'h8: cls = CL_INT;
      4'h4:                         cls = CL_FADD;
      4'h5:                         cls = CL_FMUL;
      4'h6, 4'h7:                   cls = CL_LSB;
      4'hF:                         cls = CL_NOP;
      default:                      cls = CL_ILL;
    endcase
  end

  always_comb begin
    hold_vld      = (state == HOLD);
    target_free   = 1'b0;
    unique case (cls)
      CL_INT:  target_free = bus.rs_int_free;
      CL_FADD: target_free = bus.rs_fadd_free;
      CL_FMUL: target_free = bus.rs_fmul_free;
      CL_LSB:  target_free = bus.lsb_free;
      default: target_free = 1'b0;
    endcase

    // NOP and illegal entries retire regardless of back-end availability
    fire = hold_vld & ~flush &
           ((cls == CL_NOP) | (cls == CL_ILL) | (target_free & ~bus.rob_full));
    ready  = rst_n & ~flush & (~hold_vld | fire);
    accept = bus.iq_valid & ready;

    bus.iq_ready  = ready;
    bus.disp_int  = fire & (cls == CL_INT);
    bus.disp_fadd = fire & (cls == CL_FADD);
    bus.disp_fmul = fire & (cls == CL_FMUL);
    bus.disp_lsb  = fire & (cls == CL_LSB);
    issue = bus.disp_int | bus.disp_fadd | bus.disp_fmul | bus.disp_lsb;

    bus.disp_instr = hold_instr;
    bus.disp_tag   = tag;

    state_nxt = state;
    if (flush)       state_nxt = EMPTY;
    else if (accept) state_nxt = HOLD;
    else if (fire)   state_nxt = EMPTY;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_instr   <= '0;
      tag          <= '0;
      illegal_op   <= 1'b0;
      stall_cycles <= '0;
    end else begin
      if (accept)
        hold_instr <= bus.iq_instr;
      if (issue)
        tag <= tag + 1'b1;
      if (fire && cls == CL_ILL)
        illegal_op <= 1'b1;
      if (hold_vld && !fire && !flush && stall_cycles != '1)
        stall_cycles <= stall_cycles + 1'b1;
    end
  end

endmodule

// File: tb/tb_instruction_dispatch.sv
// Directed bench for instruction_dispatch: a cycle model of the dispatcher
// checked every cycle, plus hand-computed expectations per scenario.
module tb_instruction_dispatch;
  localparam int unsigned TAG_W   = 4;
  localparam int unsigned STALL_W = 16;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               flush = 1'b0;
  logic               illegal_op;
  logic [STALL_W-1:0] stall_cycles;

  instruction_dispatch_if #(.TAG_W(TAG_W)) bus();

  instruction_dispatch #(.TAG_W(TAG_W), .STALL_W(STALL_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .bus          (bus.master),
    .illegal_op   (illegal_op),
    .stall_cycles (stall_cycles)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [74:0] act, input logic [74:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [74:0] mk(input logic [3:0] op);
    logic [31:0] a = $urandom;
    logic [31:0] b = $urandom;
    logic [6:0]  c = 7'($urandom);
    return {op, a, b, c};
  endfunction

  // 0..3 = int/fadd/fmul/lsb unit index, 4 = NOP, 5 = illegal
  function automatic int unit_of(input logic [3:0] op);
    if (op inside {[4'h0:4'h3], 4'h8}) return 0;
    if (op == 4'h4)                    return 1;
    if (op == 4'h5)                    return 2;
    if (op inside {4'h6, 4'h7})        return 3;
    if (op == 4'hF)                    return 4;
    return 5;
  endfunction

  function automatic logic [3:0] strobes();
    return {bus.disp_lsb, bus.disp_fmul, bus.disp_fadd, bus.disp_int};
  endfunction

  // ---------------- behavioural model + per-cycle compare ----------------
  logic [74:0] m_held[$];
  int          m_tag   = 0;
  bit          m_ill   = 0;
  int          m_stall = 0;

  initial begin
    logic [74:0] n_held[$];
    int          n_tag, n_stall, u;
    bit          n_ill, hv, fire, rdy;
    bit          fr[4];
    logic [3:0]  exp_str;
    forever begin
      @(negedge clk);
      #3;
      if (!rst_n) begin
        chk("m_iq_ready", 75'(bus.iq_ready), '0);
        chk("m_strobes", 75'(strobes()), '0);
        chk("m_tag", 75'(bus.disp_tag), '0);
        chk("m_illegal", 75'(illegal_op), '0);
        chk("m_stall", 75'(stall_cycles), '0);
        chk("m_instr", bus.disp_instr, '0);
      end else begin
        hv   = (m_held.size() != 0);
        fr   = '{bus.rs_int_free, bus.rs_fadd_free, bus.rs_fmul_free, bus.lsb_free};
        u    = hv ? unit_of(m_held[0][74:71]) : 4;
        fire = hv && !flush && (u >= 4 || (fr[u] && !bus.rob_full));
        rdy  = !flush && (!hv || fire);
        exp_str = '0;
        if (fire && u < 4) exp_str[u] = 1'b1;
        chk("m_iq_ready", 75'(bus.iq_ready), 75'(rdy));
        chk("m_strobes", 75'(strobes()), 75'(exp_str));
        chk("m_tag", 75'(bus.disp_tag), 75'(m_tag % 16));
        chk("m_illegal", 75'(illegal_op), 75'(m_ill));
        chk("m_stall", 75'(stall_cycles), 75'(m_stall));
        if (hv) chk("m_instr", bus.disp_instr, m_held[0]);

        n_held  = m_held;
        n_tag   = m_tag + ((exp_str != 0) ? 1 : 0);
        n_ill   = m_ill || (fire && u == 5);
        n_stall = (hv && !fire && !flush && m_stall < 65535) ? m_stall + 1 : m_stall;
        if (flush)                      n_held = {};
        else if (bus.iq_valid && rdy)   n_held = {bus.iq_instr};
        else if (fire)                  n_held = {};
      end
      @(posedge clk);
      if (!rst_n) begin
        m_held = {}; m_tag = 0; m_ill = 0; m_stall = 0;
      end else begin
        m_held = n_held; m_tag = n_tag; m_ill = n_ill; m_stall = n_stall;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic drive(input bit v, input logic [3:0] op);
    bus.iq_valid = v;
    bus.iq_instr = mk(op);
  endtask

  initial begin
    bus.iq_valid = 0; bus.iq_instr = '0;
    bus.rs_int_free = 1; bus.rs_fadd_free = 1; bus.rs_fmul_free = 1;
    bus.lsb_free = 1; bus.rob_full = 0;

    @(negedge clk); #4;
    chk("reset_ready", 75'(bus.iq_ready), '0);
    chk("reset_stall", 75'(stall_cycles), '0);
    @(negedge clk); rst_n = 1;

    // FP add issues one cycle after accept with tag 0, next issue tag 1
    @(negedge clk); drive(1, 4'h4); #4;
    chk("fadd_accept_ready", 75'(bus.iq_ready), 75'(1));
    chk("fadd_accept_nostrobe", 75'(strobes()), '0);
    @(negedge clk); drive(1, 4'h0); #4;
    chk("fadd_strobe", 75'(strobes()), 75'(4'b0010));
    chk("fadd_tag", 75'(bus.disp_tag), 75'(0));
    @(negedge clk); drive(0, 4'h0); #4;
    chk("int_after_fadd", 75'(strobes()), 75'(4'b0001));
    chk("int_after_fadd_tag", 75'(bus.disp_tag), 75'(1));
    @(negedge clk); #4;
    chk("idle_tag", 75'(bus.disp_tag), 75'(2));

    // FP mul blocked for 3 cycles; younger int waits behind it
    @(negedge clk); bus.rs_fmul_free = 0; drive(1, 4'h5); #4;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); drive(1, 4'h0); #4;
      chk("fmul_blocked_strobes", 75'(strobes()), '0);
      chk("fmul_blocked_ready", 75'(bus.iq_ready), '0);
    end
    @(negedge clk); bus.rs_fmul_free = 1; drive(1, 4'h0); #4;
    chk("fmul_strobe", 75'(strobes()), 75'(4'b0100));
    chk("fmul_stall", 75'(stall_cycles), 75'(3));
    chk("fmul_tag", 75'(bus.disp_tag), 75'(2));
    @(negedge clk); drive(0, 4'h0); #4;
    chk("int_after_fmul", 75'(strobes()), 75'(4'b0001));
    chk("int_after_fmul_tag", 75'(bus.disp_tag), 75'(3));

    // Back-to-back integer issues across the tag wrap
    @(negedge clk); rst_n = 0;
    @(negedge clk); rst_n = 1;
    for (int i = 0; i <= 16; i++) begin
      @(negedge clk); drive(1, (i % 5 == 4) ? 4'h8 : 4'(i % 4)); #4;
      if (i > 0) begin
        chk("b2b_strobe", 75'(strobes()), 75'(4'b0001));
        chk("b2b_tag", 75'(bus.disp_tag), 75'((i - 1) % 16));
      end
    end
    @(negedge clk); drive(0, 4'h0); #4;
    chk("wrap_strobe", 75'(strobes()), 75'(4'b0001));
    chk("wrap_tag", 75'(bus.disp_tag), 75'(0));

    // Illegal then NOP: no strobe, no tag, sticky flag
    @(negedge clk); drive(1, 4'hA); #4;
    @(negedge clk); drive(1, 4'hF); #4;
    chk("illegal_nostrobe", 75'(strobes()), '0);
    chk("illegal_flag_pre", 75'(illegal_op), '0);
    @(negedge clk); drive(1, 4'h1); #4;
    chk("nop_nostrobe", 75'(strobes()), '0);
    chk("illegal_flag", 75'(illegal_op), 75'(1));
    @(negedge clk); drive(0, 4'h0); #4;
    chk("post_nop_int", 75'(strobes()), 75'(4'b0001));
    chk("post_nop_tag", 75'(bus.disp_tag), 75'(1));
    @(negedge clk); #4;
    chk("illegal_sticky", 75'(illegal_op), 75'(1));

    // Flush while blocked on a full ROB
    @(negedge clk); bus.rob_full = 1; drive(1, 4'h6); #4;
    @(negedge clk); drive(1, 4'h2); #4;
    chk("robfull_nostrobe", 75'(strobes()), '0);
    @(negedge clk); flush = 1; drive(1, 4'h2); #4;
    chk("flush_ready", 75'(bus.iq_ready), '0);
    chk("flush_nostrobe", 75'(strobes()), '0);
    @(negedge clk); flush = 0; bus.rob_full = 0; drive(0, 4'h0); #4;
    chk("flush_dropped", 75'(strobes()), '0);
    chk("flush_tag", 75'(bus.disp_tag), 75'(2));
    chk("flush_stall", 75'(stall_cycles), 75'(1));

    // Asynchronous reset in the middle of a held entry
    @(negedge clk); bus.rob_full = 1; drive(1, 4'h7); #4;
    @(negedge clk); drive(0, 4'h0); #1; rst_n = 0; #1;
    chk("async_ready", 75'(bus.iq_ready), '0);
    chk("async_strobes", 75'(strobes()), '0);
    chk("async_tag", 75'(bus.disp_tag), '0);
    chk("async_illegal", 75'(illegal_op), '0);
    chk("async_stall", 75'(stall_cycles), '0);
    chk("async_instr", bus.disp_instr, '0);
    @(negedge clk); rst_n = 1; bus.rob_full = 0; #4;
    chk("post_reset_nostrobe", 75'(strobes()), '0);
    chk("post_reset_ready", 75'(bus.iq_ready), 75'(1));
    @(negedge clk); #4;
    chk("post_reset_nostrobe2", 75'(strobes()), '0);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
